// File: rtl/pixel_scan_counter_pkg.sv
// Shared GPU scan definitions: coordinate width, default frame geometry
// and the scan state encoding used by the pixel counter pipe.
package pixel_scan_counter_pkg;

  // Width of the x/y coordinate buses; 2047 is the largest legal extent.
  localparam int PIX_W = 11;

  // Default frame geometry (720p) and forced-skip counter width.
  localparam int H_ACTIVE_DEF = 1280;
  localparam int V_ACTIVE_DEF = 720;
  localparam int CNT_W_DEF    = 16;

  // Scan sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/pixel_scan_counter.sv
// Pixel counter pipe: walks x/y across the active frame, presenting each
// coordinate to the palette pipe as a request. A coordinate advances when
// the palette pipe accepts it or when the pixel count controller forces a
// skip (the palette pipe already resolved that pixel). Forced skips that
// were not also accepted are counted per frame, saturating.
module pixel_scan_counter
  import pixel_scan_counter_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             gpuClock,
  input  logic             gpuReset_n,
  input  logic             frameStart,
  input  logic             pixelIncForce,
  input  logic             reqReady,
  output logic             reqValid,
  output logic [PIX_W-1:0] xPixel_pixelCnt,
  output logic [PIX_W-1:0] yPixel_pixelCnt,
  output logic             lineDone,
  output logic             frameDone,
  output logic             busy,
  output logic [CNT_W-1:0] forcedCount
);

  // Last coordinate in each direction; wrap happens here, well before 2047.
  localparam logic [PIX_W-1:0] X_LAST  = PIX_W'(H_ACTIVE - 1);
  localparam logic [PIX_W-1:0] Y_LAST  = PIX_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  scan_state_e      state_q, state_d;
  logic [PIX_W-1:0] x_q, x_d;
  logic [PIX_W-1:0] y_q, y_d;
  logic             line_done_q, line_done_d;
  logic [CNT_W-1:0] forced_q, forced_d;

  logic scanning;
  logic accepted;
  logic advance;
  logic at_line_end;
  logic at_frame_end;

  // A request is outstanding for the whole SCAN state, so acceptance is
  // simply reqReady while scanning; a simultaneous force still advances once.
  assign scanning     = (state_q == ST_SCAN);
  assign accepted     = scanning && reqReady;
  assign advance      = scanning && (reqReady || pixelIncForce);
  assign at_line_end  = (x_q == X_LAST);
  assign at_frame_end = at_line_end && (y_q == Y_LAST);

  // Sequencer and x/y wrap counter: next state, next coordinate and the
  // line-complete pulse, which is registered so it appears the cycle after
  // the last pixel of a line advanced.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    line_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (frameStart) begin
          state_d = ST_SCAN;
          x_d     = '0;
          y_d     = '0;
        end
      end
      ST_SCAN: begin
        if (advance) begin
          if (at_line_end) begin
            line_done_d = 1'b1;
            if (at_frame_end) begin
              // Final pixel: coordinates hold so downstream sees where we stopped.
              state_d = ST_DONE;
            end else begin
              x_d = '0;
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Forced-skip counter: cleared on frame start, counts forces that were
  // not also an accepted request, saturates, and holds once the frame ends.
  always_comb begin
    forced_d = forced_q;
    if ((state_q == ST_IDLE) && frameStart) begin
      forced_d = '0;
    end else if (scanning && pixelIncForce && !accepted && (forced_q != CNT_MAX)) begin
      forced_d = forced_q + 1'b1;
    end
  end

  // State and datapath registers; reset drops everything to zero with no pulses.
  always_ff @(posedge gpuClock or negedge gpuReset_n) begin
    if (!gpuReset_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      line_done_q <= 1'b0;
      forced_q    <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      line_done_q <= line_done_d;
      forced_q    <= forced_d;
    end
  end

  assign reqValid        = scanning;
  assign busy            = scanning;
  assign frameDone       = (state_q == ST_DONE);
  assign lineDone        = line_done_q;
  assign xPixel_pixelCnt = x_q;
  assign yPixel_pixelCnt = y_q;
  assign forcedCount     = forced_q;

endmodule

// File: tb/tb_pixel_scan_counter.sv
// Self-checking bench for pixel_scan_counter on a 4x3 frame. Two instances
// share stimulus: one with a 16-bit forced counter, one with a 2-bit counter
// to exercise saturation. Expected values come from a pixel-index model.
module tb_pixel_scan_counter;

  localparam int H    = 4;
  localparam int V    = 3;
  localparam int NPIX = H * V;

  logic        gpuClock;
  logic        gpuReset_n;
  logic        frameStart;
  logic        pixelIncForce;
  logic        reqReady;

  logic        reqValidA, lineDoneA, frameDoneA, busyA;
  logic [10:0] xA, yA;
  logic [15:0] forcedA;
  logic        reqValidB, lineDoneB, frameDoneB, busyB;
  logic [10:0] xB, yB;
  logic [1:0]  forcedB;

  int checks = 0;
  int errors = 0;
  int lineCnt = 0;

  // Reference model: scan mode (0 idle, 1 scan, 2 done), linear pixel index,
  // unsaturated forced-skip count and the expected pulses.
  int mMode;
  int mPix;
  int mForced;
  bit mLine;
  bit mFrame;

  pixel_scan_counter #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(16)) dutA (
    .gpuClock(gpuClock), .gpuReset_n(gpuReset_n), .frameStart(frameStart),
    .pixelIncForce(pixelIncForce), .reqReady(reqReady), .reqValid(reqValidA),
    .xPixel_pixelCnt(xA), .yPixel_pixelCnt(yA), .lineDone(lineDoneA),
    .frameDone(frameDoneA), .busy(busyA), .forcedCount(forcedA)
  );

  pixel_scan_counter #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(2)) dutB (
    .gpuClock(gpuClock), .gpuReset_n(gpuReset_n), .frameStart(frameStart),
    .pixelIncForce(pixelIncForce), .reqReady(reqReady), .reqValid(reqValidB),
    .xPixel_pixelCnt(xB), .yPixel_pixelCnt(yB), .lineDone(lineDoneB),
    .frameDone(frameDoneB), .busy(busyB), .forcedCount(forcedB)
  );

  initial gpuClock = 1'b0;
  always #5 gpuClock = ~gpuClock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mMode   = 0;
    mPix    = 0;
    mForced = 0;
    mLine   = 0;
    mFrame  = 0;
  endtask

  task automatic modelStep(input bit fs, input bit force_in, input bit ready);
    mLine = 0;
    case (mMode)
      0: if (fs) begin
           mMode   = 1;
           mPix    = 0;
           mForced = 0;
         end
      1: if (ready || force_in) begin
           if (force_in && !ready) mForced++;
           if (mPix == NPIX - 1) begin
             mMode = 2;
             mLine = 1;
           end else begin
             if (mPix % H == H - 1) mLine = 1;
             mPix++;
           end
         end
      default: mMode = 0;
    endcase
    mFrame = (mMode == 2);
  endtask

  task automatic checkOutput();
    bit scanExp;
    scanExp = (mMode == 1);
    if (lineDoneA === 1'b1) lineCnt++;
    check("reqValidA",  32'(reqValidA),  32'(scanExp));
    check("busyA",      32'(busyA),      32'(scanExp));
    check("xA",         32'(xA),         32'(mPix % H));
    check("yA",         32'(yA),         32'(mPix / H));
    check("lineDoneA",  32'(lineDoneA),  32'(mLine));
    check("frameDoneA", 32'(frameDoneA), 32'(mFrame));
    check("forcedA",    32'(forcedA),    32'((mForced > 65535) ? 65535 : mForced));
    check("xB",         32'(xB),         32'(mPix % H));
    check("yB",         32'(yB),         32'(mPix / H));
    check("frameDoneB", 32'(frameDoneB), 32'(mFrame));
    check("forcedB",    32'(forcedB),    32'((mForced > 3) ? 3 : mForced));
  endtask

  task automatic applyStimulus(input bit fs, input bit force_in, input bit ready);
    frameStart    = fs;
    pixelIncForce = force_in;
    reqReady      = ready;
    @(posedge gpuClock);
    modelStep(fs, force_in, ready);
    #1;
    checkOutput();
  endtask

  // Asynchronous reset taken mid-cycle, checked before any clock edge.
  task automatic asyncReset();
    gpuReset_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(posedge gpuClock);
    #1;
    checkOutput();
    gpuReset_n = 1'b1;
  endtask

  initial begin
    gpuReset_n    = 1'b0;
    frameStart    = 1'b0;
    pixelIncForce = 1'b0;
    reqReady      = 1'b0;
    modelReset();
    @(posedge gpuClock);
    #1;
    checkOutput();
    gpuReset_n = 1'b1;

    // Full frame with the palette pipe always ready.
    lineCnt = 0;
    applyStimulus(1, 0, 1);
    for (int i = 0; i < NPIX; i++) applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    check("t1_lineCount", 32'(lineCnt), 32'd3);
    check("t1_forced", 32'(forcedA), 32'd0);

    // Stall at (1,0), then force a skip at (2,1) with ready low.
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0);
    check("t2_x", 32'(xA), 32'd1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 0);
    check("t3_x", 32'(xA), 32'd3);
    check("t3_forced", 32'(forcedA), 32'd1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1);

    // Force and accept together advance once and do not count.
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 1);
    check("t4_x", 32'(xA), 32'd1);
    check("t4_forced", 32'(forcedA), 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1);

    // Reset mid-frame at (2,1), then restart.
    asyncReset();
    check("t5_x", 32'(xA), 32'd0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);

    // frameStart during SCAN ignored; force while IDLE ignored.
    applyStimulus(0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0);
    check("t6_busy", 32'(busyA), 32'd0);

    // Force every cycle: 12 skips, 2-bit counter pins at 3.
    applyStimulus(1, 0, 0);
    for (int i = 0; i < NPIX; i++) applyStimulus(0, 1, 0);
    check("t7_forcedA", 32'(forcedA), 32'd12);
    check("t7_forcedB", 32'(forcedB), 32'd3);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        asyncReset();
      end else begin
        applyStimulus($urandom_range(0, 9) == 0,
                      $urandom_range(0, 3) == 0,
                      $urandom_range(0, 2) != 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
